// File: rtl/sync_burst_sequencer.sv
// rtl/sync_burst_sequencer.sv - programmable sync burst generator; SYNC_POLARITY_EN adds sync_invert_i
module sync_burst_sequencer #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [CNT_W-1:0]   cfg_period_i,
    input  logic [CNT_W-1:0]   cfg_high_i,
    input  logic [CNT_W-1:0]   cfg_delay_i,
    input  logic [BURST_W-1:0] cfg_count_i,
`ifdef SYNC_POLARITY_EN
    input  logic               sync_invert_i,
`endif
    output logic               syncout_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o,
    output logic [BURST_W-1:0] pulse_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [BURST_W-1:0] PIDX_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]   low_q, low_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic               stop_pend_q, stop_pend_d;
    logic               inv_q, inv_d;
    logic               syncout_q, syncout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [BURST_W-1:0] pulse_idx_q, pulse_idx_d;

    logic               invert_in;
    logic               cfg_valid;
    logic [CNT_W-1:0]   cnt_inc;

`ifdef SYNC_POLARITY_EN
    assign invert_in = sync_invert_i;
`else
    assign invert_in = 1'b0;
`endif

    assign cfg_valid = (cfg_period_i >= CNT_TWO) && (cfg_high_i != '0) && (cfg_high_i < cfg_period_i);
    assign cnt_inc   = cnt_q + CNT_ONE;

    // State register plus registered outputs and latched configuration
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
            delay_q     <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            inv_q       <= 1'b0;
            syncout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            low_q       <= low_d;
            delay_q     <= delay_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            inv_q       <= inv_d;
            syncout_q   <= syncout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            pulse_idx_q <= pulse_idx_d;
        end
    end

    // Next-state logic; outputs are derived from the state being entered so they line up with it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_d      = high_q;
        low_d       = low_q;
        delay_d     = delay_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        inv_d       = inv_q;
        cfg_err_d   = 1'b0;
        pulse_idx_d = pulse_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    if (cfg_valid) begin
                        high_d      = cfg_high_i;
                        low_d       = cfg_period_i - cfg_high_i;
                        delay_d     = cfg_delay_i;
                        count_d     = cfg_count_i;
                        inv_d       = invert_in;
                        stop_pend_d = 1'b0;
                        cnt_d       = '0;
                        if (cfg_delay_i != '0) begin
                            state_d     = S_DELAY;
                            pulse_idx_d = '0;
                        end else begin
                            state_d     = S_HIGH;
                            pulse_idx_d = PIDX_ONE;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                // A stop here aborts before any pulse is emitted
                if (stop_i) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else if (cnt_inc == delay_q) begin
                    state_d     = S_HIGH;
                    cnt_d       = '0;
                    pulse_idx_d = pulse_idx_q + PIDX_ONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HIGH: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_inc == high_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOW: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_inc == low_q) begin
                    cnt_d = '0;
                    if ((count_q != '0) && (pulse_idx_q == count_q)) begin
                        state_d = S_DONE;
                    end else if (stop_pend_q || stop_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_HIGH;
                        pulse_idx_d = pulse_idx_q + PIDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
                cnt_d       = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        syncout_d = (state_d == S_HIGH) ^ inv_d;
        busy_d    = (state_d == S_DELAY) || (state_d == S_HIGH) || (state_d == S_LOW);
        done_d    = (state_d == S_DONE);
    end

    assign syncout_o   = syncout_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign pulse_idx_o = pulse_idx_q;

endmodule

// File: doc/sync_burst_sequencer.md
Name: sync_burst_sequencer

Overview:
Programmable sequencer for the board sync output. It replaces the fixed free-running divide-and-toggle path with a controlled generator. On a start command it latches a configuration, optionally waits an initial delay, then emits a burst of N pulses with programmable period and high time on syncout. Count 0 selects continuous mode. Used by the acquisition controller to arm, sequence and stop sync trains for external instruments.

Parameters:
CNT_W, 32, width of period/high/delay counters and config inputs
BURST_W, 16, width of burst count config and pulse index output

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle command; latches cfg_* and begins sequence (honoured only in IDLE)
stop  input  1  one-cycle command; requests early termination
cfg_period  input  CNT_W  pulse period in clk cycles (rising edge to rising edge)
cfg_high  input  CNT_W  high time in clk cycles
cfg_delay  input  CNT_W  cycles from start to first rising edge, minus 1 (0 = no extra delay)
cfg_count  input  BURST_W  pulses per burst; 0 = continuous until stop
syncout  output  1  registered sync output
busy  output  1  high while sequence active
done  output  1  one-cycle pulse at sequence end (normal or stopped)
cfg_err  output  1  one-cycle pulse when start is rejected for invalid config
pulse_idx  output  BURST_W  rising edges emitted in current burst

Behaviour:
- Reset (async, any time incl. mid-burst): state IDLE; syncout=0, busy=0, done=0, cfg_err=0, pulse_idx=0. All internal counters and latched config go to 0.
- All outputs are registered. Config is latched at start; cfg_* changes during a burst have no effect.
- States: IDLE, DELAY, HIGH, LOW, DONE.
- IDLE: start=1 and stop=0 -> validate. Valid requires cfg_period>=2, cfg_high>=1 and cfg_high<cfg_period.
  - Invalid: cfg_err=1 for the next cycle; remain IDLE.
  - Valid: latch config, pulse_idx<=0, busy<=1. Go to DELAY if cfg_delay!=0, else HIGH.
- start with stop in the same cycle while in IDLE: ignored (no cfg_err).
- DELAY: hold syncout=0 for cfg_delay cycles, then HIGH. With start sampled at cycle 0, the first rising edge of syncout is at cycle 1+cfg_delay.
- HIGH: syncout=1 for cfg_high cycles; pulse_idx increments on entry (the rising edge).
- LOW: syncout=0 for cfg_period-cfg_high cycles. At the end of LOW:
  - If cfg_count!=0 and pulse_idx==cfg_count, go to DONE.
  - Else if a stop is pending, go to DONE.
  - Else go to HIGH.
- DONE: one cycle; done=1, busy=0, syncout=0; then IDLE. pulse_idx holds its final value until the next accepted start.
- stop handling:
  - In DELAY: go to DONE next cycle; no pulse is emitted.
  - In HIGH/LOW: set a pending flag; the current period completes fully, then DONE. There are no truncated pulses.
  - In IDLE/DONE: ignored.
- start while busy (DELAY/HIGH/LOW/DONE): ignored.
- Continuous mode (cfg_count=0): pulse_idx wraps 2^BURST_W-1 -> 0 and the burst continues.
- Counters are compared with equality on CNT_W-bit values; no overflow is possible for valid config.

Optional Feature:
SYNC_POLARITY_EN
- Defined: adds input sync_invert (1 bit), latched at start with the other config. syncout is XORed with the latched value in HIGH/LOW/DELAY. In IDLE and DONE, syncout sits at the latched idle level, which is the latched sync_invert. At reset syncout=0 and the latch is 0.
- Undefined: no sync_invert port; active-high output as described above.

Test Plan:
- Basic burst: period=10, high=4, delay=0, count=3, start@0 -> rising edges at cycles 1, 11, 21; each high 4 cycles; done pulse at cycle 31; busy 1 for cycles 1-30; pulse_idx=3.
- Delay: period=4, high=1, delay=5, count=1 -> single rising edge at cycle 6; done at cycle 10.
- Invalid config: high=10, period=10 -> cfg_err pulse next cycle, busy stays 0, syncout 0. Repeat with period=1 -> same.
- Continuous + stop: count=0, period=6, high=3; stop asserted in the 2nd HIGH cycle of pulse 5 -> pulse 5 completes, done at end of its LOW, pulse_idx=5.
- Stop in DELAY and start ignored while busy: delay=100, stop@10 -> done@11, no syncout edge. During a burst, start with new cfg -> timing unchanged.
- Async reset mid-HIGH: reset asserted between clock edges -> syncout, busy, pulse_idx 0 immediately. After release, a new start behaves as in the basic burst case.
